// File: rtl/hit_cnt_pkg.sv
// Shared definitions for the hit-window counter slice.
//   state_e   : FSM state encoding (IDLE / COUNT)
//   CNT_W_MAX : widest accumulator sat_inc can serve
//   sat_inc   : one saturating increment step, returns {sat, acc_next}
package hit_cnt_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int CNT_W_MAX = 16;

  // Callers zero-extend their accumulator and pass their own all-ones value
  // as acc_max, so one function serves every CNT_W up to CNT_W_MAX. When the
  // accumulator already sits at acc_max, a hit is lost: the value holds and
  // the sat bit reports it.
  function automatic logic [CNT_W_MAX:0] sat_inc(
    input logic [CNT_W_MAX-1:0] acc,
    input logic [CNT_W_MAX-1:0] acc_max,
    input logic                 en
  );
    logic [CNT_W_MAX:0] res;
    res = {1'b0, acc};
    if (en) begin
      if (acc == acc_max) res = {1'b1, acc};
      else                res = {1'b0, acc + CNT_W_MAX'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/hit_sat_counter.sv
// Saturating hit accumulator with sticky saturation flag.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero acc and sat on the next edge (wins over en)
//   en         : count one hit this cycle
//   count_next : value acc takes after this cycle's hit (if any)
//   sat_next   : saturation flag including this cycle's hit (if any)
// The *_next outputs let the parent capture a window result that already
// includes the hit arriving in the window's last cycle.
module hit_sat_counter
  import hit_cnt_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count_next,
  output logic             sat_next
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]   acc;
  logic               sat_r;
  logic [CNT_W_MAX:0] inc_res;

  // NOTE: every variable assigned in always_comb gets a value on every path;
  // otherwise synthesis infers a latch.
  always_comb begin
    inc_res    = sat_inc(CNT_W_MAX'(acc), CNT_W_MAX'(ACC_MAX), en);
    count_next = CNT_W'(inc_res[CNT_W_MAX-1:0]);
    sat_next   = sat_r | inc_res[CNT_W_MAX];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      sat_r <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      sat_r <= 1'b0;
    end else begin
      acc   <= count_next;
      sat_r <= sat_next;
    end
  end

endmodule

// File: rtl/mealy_hit_window_counter.sv
// Counts detector hit pulses over a window of WIN_LEN clocks and offers the
// saturated count on a valid/ready port. Supports one-shot and back-to-back
// windows; a result that cannot be delivered is dropped and flagged.
//   clk, reset : clock, asynchronous active-low reset
//   det        : hit pulse, one hit per high cycle
//   start      : opens a window when idle
//   cont       : sampled at window end, 1 reopens a window with no gap
//   busy       : window open
//   cnt_valid / cnt_ready / cnt_data / cnt_sat : result handshake
//   ovr_err    : sticky, a result was dropped
module mealy_hit_window_counter
  import hit_cnt_pkg::*;
#(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  input  logic             cnt_ready,
  output logic             ovr_err
);

  localparam int               IDX_W    = $clog2(WIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_e           state;
  logic [IDX_W-1:0] win_idx;
  logic             win_last;
  logic             acc_clear;
  logic             acc_en;
  logic [CNT_W-1:0] count_next;
  logic             sat_next;

  assign busy     = (state == ST_COUNT);
  assign win_last = busy && (win_idx == LAST_IDX);
  assign acc_en   = busy && det;
  // The accumulator restarts when a window opens from idle or reopens
  // back-to-back; a one-shot window leaves it alone until the next start.
  assign acc_clear = ((state == ST_IDLE) && start) || (win_last && cont);

  hit_sat_counter #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear      (acc_clear),
    .en         (acc_en),
    .count_next (count_next),
    .sat_next   (sat_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      win_idx   <= '0;
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
      cnt_sat   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      if (cnt_valid && cnt_ready) cnt_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_COUNT;
            win_idx <= '0;
          end
        end
        ST_COUNT: begin
          if (win_last) begin
            // A result may load into an empty register or into one being
            // accepted this very edge; the later assignment of cnt_valid
            // overrides the accept-clear above.
            if (!cnt_valid || cnt_ready) begin
              cnt_valid <= 1'b1;
              cnt_data  <= count_next;
              cnt_sat   <= sat_next;
            end else begin
              ovr_err <= 1'b1;
            end
            win_idx <= '0;
            if (!cont) state <= ST_IDLE;
          end else begin
            win_idx <= win_idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mealy_hit_window_counter.sv
// Directed self-checking bench for mealy_hit_window_counter (WIN_LEN=16,
// CNT_W=4). Inputs change and outputs are sampled 1 time unit after posedge.
module tb_mealy_hit_window_counter;

  localparam int WIN_LEN = 16;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             reset;
  logic             det;
  logic             start;
  logic             cont;
  logic             busy;
  logic             cnt_valid;
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_sat;
  logic             cnt_ready;
  logic             ovr_err;

  int n_checks = 0;
  int n_fail   = 0;

  mealy_hit_window_counter #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .det       (det),
    .start     (start),
    .cont      (cont),
    .busy      (busy),
    .cnt_valid (cnt_valid),
    .cnt_data  (cnt_data),
    .cnt_sat   (cnt_sat),
    .cnt_ready (cnt_ready),
    .ovr_err   (ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_valid"}, 32'(cnt_valid), 32'd0);
    check({tag, "_data"},  32'(cnt_data),  32'd0);
    check({tag, "_sat"},   32'(cnt_sat),   32'd0);
    check({tag, "_ovr"},   32'(ovr_err),   32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Drives one full window; pat[k] is det in window cycle k. cnt_ready is
  // raised only in the last cycle, and cnt_valid is checked just before the
  // closing edge to pin down the result latency.
  task automatic run_window(input logic [WIN_LEN-1:0] pat, input logic cont_v,
                            input logic ready_last, input logic pre_valid);
    for (int k = 0; k < WIN_LEN; k++) begin
      det       = pat[k];
      cont      = cont_v;
      cnt_ready = (k == WIN_LEN - 1) ? ready_last : 1'b0;
      if (k == 0)           check("busy_w0", 32'(busy), 32'd1);
      if (k == WIN_LEN - 1) check("valid_pre_end", 32'(cnt_valid), 32'(pre_valid));
      tick();
    end
    det       = 1'b0;
    cont      = 1'b0;
    cnt_ready = 1'b0;
  endtask

  task automatic accept();
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    check("valid_after_accept", 32'(cnt_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    det       = 1'b0;
    start     = 1'b0;
    cont      = 1'b0;
    cnt_ready = 1'b0;
    tick();
    tick();
    check_cleared("por");
    reset = 1'b1;
    tick();

    // det is ignored while idle
    det = 1'b1;
    tick();
    tick();
    det = 1'b0;
    check("idle_det_busy", 32'(busy), 32'd0);

    // Five scattered hits, one-shot window
    do_start();
    run_window(16'h444A, 1'b0, 1'b0, 1'b0);
    check("t2_valid", 32'(cnt_valid), 32'd1);
    check("t2_data",  32'(cnt_data),  32'd5);
    check("t2_sat",   32'(cnt_sat),   32'd0);
    check("t2_busy",  32'(busy),      32'd0);
    // Result holds while not accepted
    tick();
    tick();
    check("t2_hold_data", 32'(cnt_data), 32'd5);
    accept();

    // Every cycle a hit: saturates at 15
    do_start();
    run_window(16'hFFFF, 1'b0, 1'b0, 1'b0);
    check("t3_valid", 32'(cnt_valid), 32'd1);
    check("t3_data",  32'(cnt_data),  32'd15);
    check("t3_sat",   32'(cnt_sat),   32'd1);
    accept();

    // Back-to-back windows, consumer stalled: second result dropped
    do_start();
    run_window(16'h0111, 1'b1, 1'b0, 1'b0);
    check("t4_busy_cont", 32'(busy),      32'd1);
    check("t4_valid1",    32'(cnt_valid), 32'd1);
    check("t4_data1",     32'(cnt_data),  32'd3);
    check("t4_ovr1",      32'(ovr_err),   32'd0);
    run_window(16'h007F, 1'b0, 1'b0, 1'b1);
    check("t4_data2", 32'(cnt_data),  32'd3);
    check("t4_valid2", 32'(cnt_valid), 32'd1);
    check("t4_ovr2",  32'(ovr_err),   32'd1);
    check("t4_sat2",  32'(cnt_sat),   32'd0);

    // Asynchronous reset clears everything without a clock edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_cleared("async_rst");
    tick();
    reset = 1'b1;
    tick();

    // Back-to-back windows, accept coincides with second window end
    do_start();
    run_window(16'h0111, 1'b1, 1'b0, 1'b0);
    check("t5_data1", 32'(cnt_data), 32'd3);
    run_window(16'h007F, 1'b0, 1'b1, 1'b1);
    check("t5_valid2", 32'(cnt_valid), 32'd1);
    check("t5_data2",  32'(cnt_data),  32'd7);
    check("t5_ovr",    32'(ovr_err),   32'd0);
    accept();

    // Reset aborts a window at cycle 8 after 4 hits
    do_start();
    for (int k = 0; k < 8; k++) begin
      det = (k % 2 == 0);
      tick();
    end
    det   = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_busy_rst", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < WIN_LEN + 2; k++) tick();
    check("t6_no_stale_valid", 32'(cnt_valid), 32'd0);
    do_start();
    run_window(16'h0003, 1'b0, 1'b0, 1'b0);
    check("t6_valid", 32'(cnt_valid), 32'd1);
    check("t6_data",  32'(cnt_data),  32'd2);
    check("t6_sat",   32'(cnt_sat),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
